// File: rtl/mem_responder.sv
// Word-addressed memory target for the core's req/ack bus: latches one request,
// waits WAIT_CYCLES, then pulses ack with read data or an out-of-range error.
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0]      LOAD_STATE = (WAIT_CYCLES > 0) ? WAIT : RESP;
  localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              we_s;
  logic [ADDR_W-1:0] addr_s;
  logic              oor_s;

  // With zero wait states IDLE goes straight to RESP, so the read and range
  // check must see the live request rather than the not-yet-latched copy.
  always_comb begin
    we_s   = (state == IDLE) ? we   : we_q;
    addr_s = (state == IDLE) ? addr : addr_q;
    oor_s  = ({1'b0, addr_s} >= DEPTH_L);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = LOAD_STATE;
      WAIT:    if (cnt == 4'd1) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      ack   <= (state_nx == RESP);
      err   <= (state_nx == RESP) && oor_s;
      busy  <= (state_nx != IDLE);
      if (state == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state != RESP && state_nx == RESP && !we_s)
        rdata <= oor_s ? '0 : mem[addr_s];
    end
  end

  // Memory contents survive reset; an aborted write never reaches RESP.
  always_ff @(posedge clk) begin
    if (rst && state == RESP && we_q && !oor_s)
      mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three builds (default, zero-wait, DEPTH=200)
// checked against a reference memory model through an expectation queue.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req0, we0, ack0, err0, busy0;
  logic [7:0]  addr0;
  logic [15:0] wdata0, rdata0;
  logic        req1, we1, ack1, err1, busy1;
  logic [7:0]  addr1;
  logic [15:0] wdata1, rdata1;
  logic        req2, we2, ack2, err2, busy2;
  logic [7:0]  addr2;
  logic [15:0] wdata2, rdata2;

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0));

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ack(ack1), .rdata(rdata1), .err(err1), .busy(busy1));

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .ack(ack2), .rdata(rdata2), .err(err2), .busy(busy2));

  typedef struct {
    int          d;
    logic        w;
    logic [15:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [3][256];
  logic [15:0] last_rd [3];
  int          tests = 0;
  int          fails = 0;

  function automatic int wait_of(input int d);
    return (d == 1) ? 0 : 2;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 2) ? 200 : 256;
  endfunction

  // {ack, err, busy, rdata}
  function automatic logic [18:0] outs(input int d);
    case (d)
      0:       return {ack0, err0, busy0, rdata0};
      1:       return {ack1, err1, busy1, rdata1};
      default: return {ack2, err2, busy2, rdata2};
    endcase
  endfunction

  task automatic drive(input int d, input logic r, input logic w,
                       input logic [7:0] a, input logic [15:0] wd);
    case (d)
      0:       begin req0 = r; we0 = w; addr0 = a; wdata0 = wd; end
      1:       begin req1 = r; we1 = w; addr1 = a; wdata1 = wd; end
      default: begin req2 = r; we2 = w; addr2 = a; wdata2 = wd; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t make_exp(input int d, input logic w, input logic [7:0] a);
    exp_t e;
    e.d   = d;
    e.w   = w;
    e.err = (int'(a) >= depth_of(d));
    e.rd  = w ? last_rd[d] : (e.err ? 16'h0000 : model[d][a]);
    return e;
  endfunction

  // Called #1 after a rising edge. corrupt: scramble addr/wdata during WAIT.
  task automatic do_xact(input int d, input logic w, input logic [7:0] a,
                         input logic [15:0] wd, input bit corrupt, input logic [7:0] ca);
    exp_t        e;
    logic [18:0] o;
    int          n;
    bit          got;
    e = make_exp(d, w, a);
    drive(d, 1'b1, w, a, wd);
    sb.push_back(e);
    n   = 0;
    got = 0;
    while (n < 20 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && corrupt) drive(d, 1'b1, w, ca, ~wd);
      o = outs(d);
      if (o[18]) got = 1;
      else if (n <= wait_of(d)) check("busy_in_wait", {31'd0, o[16]}, 32'd1);
    end
    e = sb.pop_front();
    check("ack_latency", n, wait_of(e.d) + 1);
    check("ack_seen", {31'd0, o[18]}, 32'd1);
    check("err", {31'd0, o[17]}, {31'd0, e.err});
    check("rdata", {16'd0, o[15:0]}, {16'd0, e.rd});
    drive(d, 1'b0, 1'b0, 8'h00, 16'h0000);
    if (w && !e.err) model[d][a] = wd;
    if (!w) last_rd[d] = e.rd;
    @(posedge clk); #1;
    o = outs(d);
    check("ack_one_cycle", {31'd0, o[18]}, 32'd0);
    check("idle_not_busy", {31'd0, o[16]}, 32'd0);
  endtask

  initial begin
    logic [18:0] o;
    exp_t        e;
    int          n;
    int          acks;

    // Reset held with req asserted on every build
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b1, 1'b1, 8'h05, 16'h1111);
      last_rd[d] = 16'h0000;
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        o = outs(d);
        check("reset_ack", {31'd0, o[18]}, 32'd0);
        check("reset_busy", {31'd0, o[16]}, 32'd0);
        check("reset_rdata", {16'd0, o[15:0]}, 32'd0);
      end
    end
    rst = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(posedge clk); #1;

    // Write then read back with two wait states
    do_xact(0, 1'b1, 8'h05, 16'hBEEF, 0, 8'h00);
    do_xact(0, 1'b0, 8'h05, 16'h0000, 0, 8'h00);

    // Inputs changed during WAIT must not affect the latched transaction
    do_xact(0, 1'b1, 8'h20, 16'h2222, 0, 8'h00);
    do_xact(0, 1'b1, 8'h10, 16'h1234, 1, 8'h20);
    do_xact(0, 1'b0, 8'h10, 16'h0000, 0, 8'h00);
    do_xact(0, 1'b0, 8'h20, 16'h0000, 1, 8'h05);

    // Reset pulsed mid-write aborts it
    drive(0, 1'b1, 1'b1, 8'h05, 16'hDEAD);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    o = outs(0);
    check("abort_ack", {31'd0, o[18]}, 32'd0);
    check("abort_busy", {31'd0, o[16]}, 32'd0);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    for (int d = 0; d < 3; d++) last_rd[d] = 16'h0000;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      o = outs(0);
      if (o[18]) acks++;
    end
    check("abort_no_ack", acks, 0);
    do_xact(0, 1'b0, 8'h05, 16'h0000, 0, 8'h00);

    // Zero wait states: fill, then back-to-back reads with req held
    for (int i = 0; i < 3; i++) do_xact(1, 1'b1, 8'(i), 16'h1000 + 16'(i * 16'h0101), 0, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h00, 16'h0000);
    sb.push_back(make_exp(1, 1'b0, 8'h00));
    for (int i = 0; i < 3; i++) begin
      n = 0;
      o = outs(1);
      while (n < 10) begin
        @(posedge clk); #1;
        n++;
        o = outs(1);
        if (o[18]) break;
      end
      e = sb.pop_front();
      check("b2b_spacing", n, (i == 0) ? 1 : 2);
      check("b2b_rdata", {16'd0, o[15:0]}, {16'd0, e.rd});
      check("b2b_err", {31'd0, o[17]}, 32'd0);
      last_rd[1] = e.rd;
      if (i < 2) begin
        drive(1, 1'b1, 1'b0, 8'(i + 1), 16'h0000);
        sb.push_back(make_exp(1, 1'b0, 8'(i + 1)));
      end else begin
        drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
    end
    @(posedge clk); #1;
    o = outs(1);
    check("b2b_end_ack", {31'd0, o[18]}, 32'd0);
    @(posedge clk); #1;

    // DEPTH=200: out-of-range read and write
    do_xact(2, 1'b1, 8'h70, 16'h7070, 0, 8'h00);
    do_xact(2, 1'b0, 8'h70, 16'h0000, 0, 8'h00);
    do_xact(2, 1'b0, 8'hF0, 16'h0000, 0, 8'h00);
    do_xact(2, 1'b1, 8'hF0, 16'hAAAA, 0, 8'h00);
    do_xact(2, 1'b0, 8'h70, 16'h0000, 0, 8'h00);
    do_xact(2, 1'b0, 8'hC7, 16'h0000, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
